branch_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters. Sits in the fetch stage, upstream of branch_alu in execute. It supplies the `pre_is_branch_taken` / `pre_branch_addr` pair that travels with each instruction to branch_alu. It is trained by branch_alu's `update_en` / `taken_or_not_actual` / `branch_actual_addr` / `pc_dispatch` outputs.

---
 rtl/branch_predictor_pkg.sv | 13 +
 rtl/sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 98 +++++++++
 tb/tb_branch_predictor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared sizing defaults and 2-bit direction counter encodings
// for the fetch-stage branch target buffer.
package branch_predictor_pkg;

  localparam int BP_IDX_W = 6;
  localparam int BP_TAG_W = 8;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

endpackage

// File: rtl/sat_counter2.sv
// Combinational next value of a 2-bit saturating
// direction counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cnt;
    if (taken) begin
      if (cnt != BP_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != BP_SNT) nxt = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; registered lookup,
// trained by branch_alu resolution.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W,
  parameter int TAG_W = BP_TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic        fetch_stall,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_addr,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target
);

  localparam int N = 1 << IDX_W;
  localparam int TH = IDX_W + TAG_W + 1;

  logic [N-1:0]     valid_q;
  logic [TAG_W-1:0] tag_q [N];
  logic [31:0]      tgt_q [N];
  logic [1:0]       cnt_q [N];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             f_hit;
  logic             u_hit;
  logic [1:0]       cnt_nxt;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[TH:IDX_W+2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[TH:IDX_W+2];

  assign f_hit = valid_q[f_idx]
              && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx]
              && (tag_q[u_idx] == u_tag);

  sat_counter2 u_cnt (
    .cnt   (cnt_q[u_idx]),
    .taken (update_taken),
    .nxt   (cnt_nxt)
  );

  // Lookups read the table before this edge's write: no bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= BP_WNT;
      end
    end else if (update_en) begin
      if (u_hit) begin
        cnt_q[u_idx] <= cnt_nxt;
        if (update_taken)
          tgt_q[u_idx] <= update_target;
      end else if (update_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= update_target;
        cnt_q[u_idx]   <= BP_WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_addr  <= '0;
    end else if (!fetch_stall) begin
      pred_valid <= fetch_valid;
      pred_taken <= fetch_valid & f_hit
                  & cnt_q[f_idx][1];
      pred_addr  <= (fetch_valid && f_hit)
                  ? tgt_q[f_idx] : 32'h0;
    end
  end

  logic unused;
  assign unused = ^{fetch_pc[1:0],
                    fetch_pc[31:TH+1],
                    update_pc[1:0],
                    update_pc[31:TH+1]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus random checks of branch_predictor against
// an array-based model of the BTB rules.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_stall;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_addr;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;

  int n_assert = 0;
  int n_fail   = 0;

  bit          m_valid [64];
  int          m_tag   [64];
  int          m_cnt   [64];
  logic [31:0] m_tgt   [64];

  logic        exp_pv;
  logic        exp_pt;
  logic [31:0] exp_pa;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_valid   (fetch_valid),
    .fetch_stall   (fetch_stall),
    .fetch_pc      (fetch_pc),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_addr     (pred_addr),
    .update_en     (update_en),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target)
  );

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc / 4) % 64;
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'(pc / 256) % 256;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_cnt[i]   = 1;
      m_tgt[i]   = 32'h0;
    end
    exp_pv = 0;
    exp_pt = 0;
    exp_pa = 32'h0;
  endtask

  task automatic m_update(input logic [31:0] pc,
                          input bit tk,
                          input logic [31:0] tgt);
    int i;
    i = idx_of(pc);
    if (m_hit(pc)) begin
      if (tk) begin
        m_cnt[i] = (m_cnt[i] >= 3) ? 3 : m_cnt[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_cnt[i] = (m_cnt[i] <= 0) ? 0 : m_cnt[i] - 1;
      end
    end else if (tk) begin
      m_valid[i] = 1;
      m_tag[i]   = tag_of(pc);
      m_tgt[i]   = tgt;
      m_cnt[i]   = 2;
    end
  endtask

  task automatic chk(input string tag);
    n_assert++;
    assert (pred_valid === exp_pv) else begin
      n_fail++;
      $error("FAIL %s pred_valid got %0b want %0b",
             tag, pred_valid, exp_pv);
    end
    if (exp_pv) begin
      n_assert++;
      assert (pred_taken === exp_pt) else begin
        n_fail++;
        $error("FAIL %s pred_taken got %0b want %0b",
               tag, pred_taken, exp_pt);
      end
      n_assert++;
      assert (pred_addr === exp_pa) else begin
        n_fail++;
        $error("FAIL %s pred_addr got %h want %h",
               tag, pred_addr, exp_pa);
      end
    end
  endtask

  task automatic want(input string tag, input logic pv,
                      input logic pt, input logic [31:0] pa);
    n_assert++;
    assert ({pred_valid, pred_taken, pred_addr}
            === {pv, pt, pa}) else begin
      n_fail++;
      $error("FAIL %s got v%0b t%0b %h want v%0b t%0b %h",
             tag, pred_valid, pred_taken, pred_addr,
             pv, pt, pa);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the next.
  task automatic cyc(input string tag,
                     input logic fv, input logic st,
                     input logic [31:0] fpc,
                     input logic ue, input logic ut,
                     input logic [31:0] upc,
                     input logic [31:0] utgt);
    int i;
    fetch_valid   = fv;
    fetch_stall   = st;
    fetch_pc      = fpc;
    update_en     = ue;
    update_taken  = ut;
    update_pc     = upc;
    update_target = utgt;
    if (!st) begin
      exp_pv = fv;
      exp_pt = 0;
      exp_pa = 32'h0;
      if (fv && m_hit(fpc)) begin
        i = idx_of(fpc);
        exp_pt = (m_cnt[i] >= 2);
        exp_pa = m_tgt[i];
      end
    end
    @(posedge clk);
    #1;
    if (ue) m_update(upc, ut, utgt);
    chk(tag);
  endtask

  localparam logic [31:0] PA = 32'h1C00_0010;
  localparam logic [31:0] PB = 32'h1C00_4010;
  localparam logic [31:0] PC = 32'h1C00_0020;
  localparam logic [31:0] TA = 32'h1C00_0100;
  localparam logic [31:0] TB = 32'h1C00_0400;
  localparam logic [31:0] TC = 32'h1C00_0200;

  initial begin
    logic [31:0] rpc;
    logic [31:0] upc;
    rst = 1'b1;
    fetch_valid = 0; fetch_stall = 0;
    fetch_pc = 0; update_en = 0;
    update_pc = 0; update_taken = 0;
    update_target = 0;
    m_reset();
    #12;
    want("reset_out", 0, 0, 32'h0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    want("reset_idle", 0, 0, 32'h0);

    cyc("cold", 1, 0, 32'h1C00_0000, 0, 0, 0, 0);
    want("cold_c", 1, 0, 32'h0);

    cyc("alloc", 0, 0, 0, 1, 1, PA, TA);
    want("alloc_c", 0, 0, 32'h0);
    cyc("hit", 1, 0, PA, 0, 0, 0, 0);
    want("hit_c", 1, 1, TA);

    for (int k = 0; k < 3; k++)
      cyc("dec", 0, 0, 0, 1, 0, PA, 32'hDEAD_BEEF);
    cyc("sat", 1, 0, PA, 0, 0, 0, 0);
    want("sat_c", 1, 0, TA);
    cyc("sat_up", 0, 0, 0, 1, 1, PA, TA);
    cyc("sat_up2", 1, 0, PA, 0, 0, 0, 0);
    want("sat_up2_c", 1, 0, TA);

    cyc("alias_w", 0, 0, 0, 1, 1, PB, TB);
    cyc("alias_a", 1, 0, PA, 0, 0, 0, 0);
    want("alias_a_c", 1, 0, 32'h0);
    cyc("alias_b", 1, 0, PB, 0, 0, 0, 0);
    want("alias_b_c", 1, 1, TB);

    cyc("coll", 1, 0, PC, 1, 1, PC, TC);
    want("coll_c", 1, 0, 32'h0);
    cyc("coll_n", 1, 0, PC, 0, 0, 0, 0);
    want("coll_n_c", 1, 1, TC);

    cyc("nofetch", 0, 0, PC, 0, 0, 0, 0);
    want("nofetch_c", 0, 0, 32'h0);
    cyc("pre_stall", 1, 0, PC, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cyc("stall", k[0], 1, PA, 1, 0, PC, 0);
      want("stall_c", 1, 1, TC);
    end
    cyc("post", 1, 0, PC, 0, 0, 0, 0);
    want("post_c", 1, 0, TC);

    fetch_stall = 1; fetch_valid = 1;
    update_en = 1; update_taken = 1;
    update_pc = PB; update_target = 32'h1;
    #2 rst = 1'b1;
    #1;
    want("rst_mid", 0, 0, 32'h0);
    m_reset();
    update_en = 0;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    cyc("rst_b", 1, 0, PB, 0, 0, 0, 0);
    want("rst_b_c", 1, 0, 32'h0);

    for (int k = 0; k < 400; k++) begin
      rpc = 32'h1C00_0000
          | ($urandom_range(0, 7) << 2)
          | ($urandom_range(0, 3) << 8);
      upc = 32'h1C00_0000
          | ($urandom_range(0, 7) << 2)
          | ($urandom_range(0, 3) << 8);
      cyc("rand",
          1'($urandom_range(0, 9) < 8),
          1'($urandom_range(0, 9) < 2),
          rpc,
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) != 0),
          upc,
          $urandom & 32'hFFFF_FFFC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
